ram_write_buffer: RTL and testbench
===================================

Name: ram_write_buffer

Overview:
- Downstream stage of the file loader: accepts the loader's byte-write stream (write strobe, 16-bit RAM address, 8-bit data) into a small FIFO.
- Drains the FIFO to the shared RAM port using a req/ack handshake, so that RAM or DMA stalls never lose bytes.
- Counts the committed bytes against a programmed transfer length and reports completion to the layer controller.

Parameters:
- ADDR_W, 16, RAM address width.
- DATA_W, 8, data byte width.
- DEPTH, 4, FIFO entries; must be a power of 2 and at least 2.
- LEN_W, 16, width of the transfer length and of the byte counters.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that arms a transfer; honoured only in IDLE or DONE.
- xfer_len  in  LEN_W  number of bytes in the transfer; sampled when start is honoured.
- in_write  in  1  loader byte-write strobe.
- in_addr  in  ADDR_W  RAM address of the loader byte.
- in_data  in  DATA_W  loader byte.
- in_ready  out  1  byte is accepted in any cycle where in_write && in_ready.
- ram_req  out  1  RAM write request; held until acknowledged.
- ram_addr  out  ADDR_W  FIFO head address.
- ram_data  out  DATA_W  FIFO head data.
- ram_ack  in  1  RAM accepted the current request this cycle.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  high in DONE; level, not a pulse.
- overflow  out  1  sticky error flag.
- bytes_written  out  LEN_W  count of acknowledged RAM writes in the current transfer.

Behaviour:
- Reset (RST=0, asynchronous): FSM=IDLE, FIFO empty, all counters 0, all outputs 0.
- FSM states and transitions:
  - IDLE / DONE -> RUN on start with xfer_len != 0: latch xfer_len, clear accepted/bytes_written/overflow, clear FIFO pointers.
  - IDLE / DONE -> DONE on start with xfer_len == 0: counters and overflow are cleared.
  - RUN -> DRAIN when accepted count reaches the latched length.
  - DRAIN -> DONE when bytes_written reaches the latched length. The FIFO is then empty.
  - DONE holds until the next start. start is ignored in RUN and DRAIN.
- in_ready = (state==RUN) && !fifo_full && (accepted < len). This is purely registered-state combinational, with no dependence on in_write.
- Push: in_write && in_ready writes {in_addr, in_data} at the tail and increments accepted.
  - Full is evaluated on current-cycle state: no write-through bypass.
  - A simultaneous pop does not free a slot for a push in the same cycle.
- Pop:
  - ram_req = !fifo_empty, in RUN or DRAIN.
  - ram_addr and ram_data always show the head entry.
  - On ram_req && ram_ack: advance head and increment bytes_written.
  - ram_ack while ram_req=0 is ignored.
- Latency: a byte pushed at edge N gives ram_req=1 after edge N when the FIFO was empty; the first RAM write is possible at edge N+1.
- Simultaneous push and pop on a non-full, non-empty FIFO: occupancy is unchanged and both counters increment.
- Overflow:
  - in_write while in_ready=0 in RUN or DRAIN sets overflow; the byte is dropped.
  - in_write in IDLE or DONE is ignored silently.
  - overflow clears only on reset or an honoured start.
- Pointers: log2(DEPTH)+1 bits, wrapping modulo 2*DEPTH.
  - full = pointers equal except the MSB.
  - empty = pointers fully equal.
- Addresses pass through unmodified; there is no range check and no increment.
- Counters never exceed the latched length and do not wrap.
- Reset mid-transfer: everything is discarded immediately, and ram_req drops asynchronously.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=2'd0, RUN=2'd1, DRAIN=2'd2, DONE=2'd3.
  - width constants ADDR_W=16, DATA_W=8, the loader's reserved start address 16'h000F.
- Sub-module sync_fifo (parameters WIDTH=ADDR_W+DATA_W and DEPTH) with push/pop/full/empty and the same clk/RST.
- The top level holds the FSM, counters and flags.

Test Plan:
- Reset then start, xfer_len=4, bytes AA,BB,CC,DD at addrs 000F–0012, ram_ack tied 1 -> four RAM writes in order with matching addrs; bytes_written=4; done=1; overflow=0.
- Start with xfer_len=6, ram_ack=0 for 10 cycles -> in_ready falls after exactly 4 pushes and ram_addr holds 000F; release ack -> all 6 bytes written in order; done=1.
- With the FIFO full, drive in_write with in_ready=0 -> overflow=1, byte absent from the RAM sequence; a new start clears overflow.
- Start with xfer_len=0 -> DONE the next cycle, ram_req never asserted, bytes_written=0.
- Assert RST low mid-transfer after 2 of 4 bytes -> ram_req, busy, done and counters go 0 immediately; a new transfer afterwards completes normally.
- Alternate ack on/off with continuous push at DEPTH-1 occupancy -> no loss, no duplication, and bytes_written equals xfer_len=8 at DONE.

Source files
------------

// File: rtl/ram_write_buffer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : ram_write_buffer_pkg                                         |
// | Description : Shared state encoding and width constants for the RAM write  |
// |               buffer that sits downstream of the file loader.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package ram_write_buffer_pkg;

  // Controller state encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int c_ADDR_W = 16;
  localparam int c_DATA_W = 8;

  // First RAM address the loader writes to; bytes before it are reserved.
  localparam logic [c_ADDR_W-1:0] c_LOADER_START_ADDR = 16'h000F;

endpackage
`default_nettype wire

// File: rtl/ram_write_buffer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : ram_write_buffer_if                                          |
// | Description : Loader byte-write stream plus the RAM req/ack write port.    |
// |   in_write/in_addr/in_data : loader byte strobe, address and data         |
// |   in_ready                 : buffer can take a byte this cycle            |
// |   ram_req/ram_addr/ram_data: RAM write request and head-of-FIFO payload   |
// |   ram_ack                  : RAM accepted the current request             |
// |   Modport slave is the buffer's view, master the environment's view.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface ram_write_buffer_if
  import ram_write_buffer_pkg::*;
#(
  parameter int ADDR_W = c_ADDR_W,
  parameter int DATA_W = c_DATA_W
);

  logic              in_write;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              ram_req;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;
  logic              ram_ack;

  modport slave (
    input  in_write, in_addr, in_data, ram_ack,
    output in_ready, ram_req, ram_addr, ram_data
  );

  modport master (
    output in_write, in_addr, in_data, ram_ack,
    input  in_ready, ram_req, ram_addr, ram_data
  );

endinterface
`default_nettype wire

// File: rtl/ram_write_buffer_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sync_fifo                                                    |
// | Description : Single-clock FIFO with extra-MSB pointers. No write-through: |
// |               full/empty reflect current state only, so a pop never frees  |
// |               a slot for a push in the same cycle.                         |
// |   clk, RST (async active-low), clr (sync pointer clear)                   |
// |   push/wdata, pop/rdata (head, always visible), full, empty               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4   // power of two, at least 2
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int c_PTR_W = $clog2(DEPTH) + 1;
  // Pointer XOR pattern that means "same slot, one lap apart".
  localparam logic [c_PTR_W-1:0] c_FULL_XOR = {1'b1, {(c_PTR_W-1){1'b0}}};

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wrPtr;
  logic [c_PTR_W-1:0] r_rdPtr;

  assign full  = (r_wrPtr ^ r_rdPtr) == c_FULL_XOR;
  assign empty = r_wrPtr == r_rdPtr;
  assign rdata = r_mem[r_rdPtr[c_PTR_W-2:0]];

  // Storage is reset too so the head output reads zero out of reset.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (clr) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (push && !full) begin
        r_mem[r_wrPtr[c_PTR_W-2:0]] <= wdata;
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (pop && !empty) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ram_write_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ram_write_buffer                                             |
// | Description : Buffers the loader's byte writes in a small FIFO and drains  |
// |               them to the shared RAM port over req/ack, counting committed |
// |               bytes against a programmed transfer length.                  |
// |   clk, RST (async active-low)                                             |
// |   start, xfer_len : arm a transfer (honoured in IDLE/DONE only)           |
// |   bus (slave)     : loader byte stream in, RAM write port out             |
// |   busy, done      : RUN/DRAIN and DONE levels                             |
// |   overflow        : sticky, byte offered while not ready during transfer  |
// |   bytes_written   : acknowledged RAM writes in the current transfer       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ram_write_buffer
  import ram_write_buffer_pkg::*;
#(
  parameter int ADDR_W = c_ADDR_W,
  parameter int DATA_W = c_DATA_W,
  parameter int DEPTH  = 4,
  parameter int LEN_W  = 16
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic                 start,
  input  logic [LEN_W-1:0]     xfer_len,
  ram_write_buffer_if.slave    bus,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic [LEN_W-1:0]     bytes_written
);

  state_t                  r_state;
  state_t                  w_nextState;
  logic [LEN_W-1:0]        r_len;
  logic [LEN_W-1:0]        r_accepted;
  logic [LEN_W-1:0]        r_bytesWritten;
  logic                    r_overflow;

  logic                    w_active;
  logic                    w_startOk;
  logic                    w_inReady;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_ramReq;
  logic                    w_overflowEv;
  logic                    w_fifoFull;
  logic                    w_fifoEmpty;
  logic [ADDR_W+DATA_W-1:0] w_head;
  logic [LEN_W-1:0]        w_accNext;
  logic [LEN_W-1:0]        w_wrNext;

  assign w_active  = (r_state == RUN) || (r_state == DRAIN);
  assign w_startOk = start && ((r_state == IDLE) || (r_state == DONE));

  // Depends on registered state only, never on in_write.
  assign w_inReady    = (r_state == RUN) && !w_fifoFull && (r_accepted < r_len);
  assign w_push       = bus.in_write && w_inReady;
  assign w_overflowEv = bus.in_write && !w_inReady && w_active;

  // Gated by state so an async reset drops the request immediately.
  assign w_ramReq = w_active && !w_fifoEmpty;
  assign w_pop    = w_ramReq && bus.ram_ack;

  // Counter values after this cycle's push/pop; the FSM compares these so it
  // leaves RUN/DRAIN on the same edge the count reaches the length.
  assign w_accNext = r_accepted + {{(LEN_W-1){1'b0}}, w_push};
  assign w_wrNext  = r_bytesWritten + {{(LEN_W-1){1'b0}}, w_pop};

  sync_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .RST   (RST),
    .clr   (w_startOk),
    .push  (w_push),
    .wdata ({bus.in_addr, bus.in_data}),
    .pop   (w_pop),
    .rdata (w_head),
    .full  (w_fifoFull),
    .empty (w_fifoEmpty)
  );

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (w_startOk) begin
          w_nextState = (xfer_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (w_accNext == r_len) begin
          w_nextState = DRAIN;
        end
      end
      DRAIN: begin
        if (w_wrNext == r_len) begin
          w_nextState = DONE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_len          <= '0;
      r_accepted     <= '0;
      r_bytesWritten <= '0;
      r_overflow     <= 1'b0;
    end else if (w_startOk) begin
      r_len          <= xfer_len;
      r_accepted     <= '0;
      r_bytesWritten <= '0;
      r_overflow     <= 1'b0;
    end else begin
      r_accepted     <= w_accNext;
      r_bytesWritten <= w_wrNext;
      if (w_overflowEv) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign bus.in_ready = w_inReady;
  assign bus.ram_req  = w_ramReq;
  assign bus.ram_addr = w_head[ADDR_W+DATA_W-1:DATA_W];
  assign bus.ram_data = w_head[DATA_W-1:0];

  assign busy          = w_active;
  assign done          = (r_state == DONE);
  assign overflow      = r_overflow;
  assign bytes_written = r_bytesWritten;

endmodule
`default_nettype wire

// File: tb/tb_ram_write_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ram_write_buffer                                          |
// | Description : Scoreboard bench. A transaction-level model accepts bytes    |
// |               by the buffer's rules and queues the expected RAM writes; a  |
// |               negedge monitor pops and compares every RAM handshake and    |
// |               checks the status outputs against the model.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_ram_write_buffer;
  import ram_write_buffer_pkg::*;

  localparam int DEPTH = 4;
  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             RST = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] xfer_len = '0;
  logic             busy;
  logic             done;
  logic             overflow;
  logic [LEN_W-1:0] bytes_written;

  ram_write_buffer_if bus ();

  ram_write_buffer #(
    .ADDR_W (c_ADDR_W),
    .DATA_W (c_DATA_W),
    .DEPTH  (DEPTH),
    .LEN_W  (LEN_W)
  ) dut (
    .clk           (clk),
    .RST           (RST),
    .start         (start),
    .xfer_len      (xfer_len),
    .bus           (bus),
    .busy          (busy),
    .done          (done),
    .overflow      (overflow),
    .bytes_written (bytes_written)
  );

  always #5 clk = ~clk;

  int nCmp = 0;
  int nBad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          mActive, mDone, mOvf;
  int          mLen, mAcc, mWr;
  logic [23:0] sbQ[$];

  function automatic bit mReady();
    return mActive && (mAcc < mLen) && ((mAcc - mWr) < DEPTH);
  endfunction

  function automatic bit mReq();
    return mActive && ((mAcc - mWr) > 0);
  endfunction

  always @(posedge clk or negedge RST) begin
    if (!RST) begin
      mActive = 0; mDone = 0; mOvf = 0;
      mLen = 0; mAcc = 0; mWr = 0;
      sbQ.delete();
    end else begin
      bit rdy, req;
      rdy = mReady();
      req = mReq();
      if (start && !mActive) begin
        mLen = int'(xfer_len); mAcc = 0; mWr = 0; mOvf = 0;
        mActive = (xfer_len != 0);
        mDone   = (xfer_len == 0);
        sbQ.delete();
      end else if (mActive) begin
        if (bus.in_write && rdy) begin
          sbQ.push_back({bus.in_addr, bus.in_data});
          mAcc++;
        end else if (bus.in_write) begin
          mOvf = 1;
        end
        if (req && bus.ram_ack) mWr++;
        if (mWr == mLen) begin
          mActive = 0;
          mDone   = 1;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    chk("in_ready", 32'(bus.in_ready), 32'(mReady()));
    chk("ram_req", 32'(bus.ram_req), 32'(mReq()));
    chk("busy", 32'(busy), 32'(mActive));
    chk("done", 32'(done), 32'(mDone));
    chk("overflow", 32'(overflow), 32'(mOvf));
    chk("bytes_written", 32'(bytes_written), 32'(mWr));
    if (bus.ram_req && bus.ram_ack) begin
      if (sbQ.size() == 0) begin
        nCmp++; nBad++;
        $display("FAIL ram_write: got unexpected write %h<-%h, expected none", bus.ram_addr, bus.ram_data);
      end else begin
        logic [23:0] e;
        e = sbQ.pop_front();
        chk("ram_addr", 32'(bus.ram_addr), 32'(e[23:8]));
        chk("ram_data", 32'(bus.ram_data), 32'(e[7:0]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idleIn();
    bus.in_write = 0;
    bus.ram_ack  = 0;
    start        = 0;
  endtask

  task automatic doStart(input int len);
    start    = 1;
    xfer_len = LEN_W'(len);
    cyc();
    start = 0;
  endtask

  task automatic drive(input bit wr, input bit pattern, input bit ack);
    bus.in_write = wr;
    bus.in_addr  = c_LOADER_START_ADDR + 16'(mAcc);
    bus.in_data  = pattern ? 8'(8'hAA + 8'h11 * mAcc) : 8'($urandom);
    bus.ram_ack  = ack;
  endtask

  // polite: only offer a byte when the model says it will be taken.
  task automatic runUntilDone(input int wrPct, input int ackPct, input bit alt,
                              input bit pattern, input bit polite, input bit stray);
    int n = 0;
    while (!done && n < 400) begin
      bit wr;
      wr = ($urandom_range(99) < wrPct) && (polite ? mReady() : (mAcc < mLen));
      drive(wr, pattern, alt ? n[0] : ($urandom_range(99) < ackPct));
      start    = stray && ($urandom_range(99) < 3);
      xfer_len = 16'($urandom_range(1, 9));
      cyc();
      n++;
    end
    idleIn();
    if (n >= 400) begin
      nCmp++; nBad++;
      $display("FAIL done_timeout: got done=0 after %0d cycles, expected done=1", n);
    end
    chk("sb_drained", 32'(sbQ.size()), 32'd0);
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_write = 0; bus.in_addr = '0; bus.in_data = '0; bus.ram_ack = 0;
    repeat (3) cyc();
    chk("reset_ram_addr", 32'(bus.ram_addr), 32'd0);
    chk("reset_ram_data", 32'(bus.ram_data), 32'd0);
    RST = 1;
    cyc();

    // 1: four pattern bytes, ack tied high
    doStart(4);
    runUntilDone(100, 100, 0, 1, 1, 0);
    chk("t1_bytes", 32'(bytes_written), 32'd4);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_ovf", 32'(overflow), 32'd0);

    // 2: RAM stalled for 10 cycles, FIFO fills after DEPTH pushes
    doStart(6);
    repeat (10) begin drive(mReady(), 1, 0); cyc(); end
    chk("t2_in_ready", 32'(bus.in_ready), 32'd0);
    chk("t2_head_addr", 32'(bus.ram_addr), 32'h000F);
    chk("t2_pushes", 32'(mAcc), 32'(DEPTH));
    runUntilDone(100, 100, 0, 1, 1, 0);
    chk("t2_bytes", 32'(bytes_written), 32'd6);

    // 3: writes into a full FIFO raise overflow; new start clears it
    doStart(6);
    repeat (8) begin drive(1, 0, 0); cyc(); end
    chk("t3_ovf", 32'(overflow), 32'd1);
    runUntilDone(100, 100, 0, 0, 1, 0);
    doStart(3);
    chk("t3_ovf_cleared", 32'(overflow), 32'd0);
    runUntilDone(100, 100, 0, 0, 1, 0);

    // 4: zero-length transfer
    doStart(0);
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_req", 32'(bus.ram_req), 32'd0);
    chk("t4_bytes", 32'(bytes_written), 32'd0);
    cyc();

    // 5: asynchronous reset with a request pending
    doStart(4);
    for (int n = 0; n < 50 && mWr < 2; n++) begin
      drive(mReady() && mAcc < 3, 0, 1); cyc();
    end
    drive(0, 0, 0);
    while (mAcc < 3) begin drive(mReady(), 0, 0); cyc(); end
    drive(0, 0, 0);
    cyc();
    chk("t5_req_before", 32'(bus.ram_req), 32'd1);
    #2 RST = 0;
    #1;
    chk("t5_req", 32'(bus.ram_req), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    chk("t5_bytes", 32'(bytes_written), 32'd0);
    cyc();
    RST = 1;
    cyc();
    doStart(4);
    runUntilDone(100, 100, 0, 0, 1, 0);
    chk("t5_bytes_after", 32'(bytes_written), 32'd4);

    // 6: prefill to DEPTH-1 then alternate ack with continuous push
    doStart(8);
    for (int n = 0; n < 20 && mAcc < DEPTH - 1; n++) begin
      drive(1, 0, 0); cyc();
    end
    runUntilDone(100, 0, 1, 0, 1, 0);
    chk("t6_bytes", 32'(bytes_written), 32'd8);
    chk("t6_ovf", 32'(overflow), 32'd0);

    // random transfers, including impolite writers and stray starts
    repeat (15) begin
      doStart($urandom_range(1, 20));
      runUntilDone($urandom_range(30, 100), $urandom_range(20, 100), 0, 0,
                   1'($urandom_range(1)), 1);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
`default_nettype wire
